// File: rtl/seg_pkg.sv
// Shared constants for the 4-digit multiplexed seven-segment driver:
// blank codes, active-low hex-to-segment table and digit-select helper.
package seg_pkg;

    localparam logic [7:0] SEG_BLANK = 8'hFF;
    localparam logic [3:0] AN_OFF    = 4'hF;

    // Active-low {g,f,e,d,c,b,a}; entry n is the glyph for hex digit n.
    localparam logic [6:0] HEX_SEG_TABLE [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30,
        7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03,
        7'h46, 7'h21, 7'h06, 7'h0E
    };

    typedef logic [1:0] digit_idx_t;

    function automatic logic [3:0] an_select(input digit_idx_t idx);
        return ~(4'b0001 << idx);
    endfunction

endpackage

// File: rtl/hex7seg.sv
// Combinational hex nibble to active-low seven-segment decoder.
module hex7seg
    import seg_pkg::*;
(
    input  logic [3:0] i_hex,
    output logic [6:0] o_seg
);

    always_comb begin
        o_seg = HEX_SEG_TABLE[i_hex];
    end

endmodule

// File: rtl/seg_scan_driver.sv
// Time-multiplexed 4-digit seven-segment scanner with per-frame input snapshot.
// Optional macro SEG_LEADING_ZERO_BLANK_EN blanks leading zero digits 3..1.
module seg_scan_driver
    import seg_pkg::*;
#(
    parameter int unsigned REFRESH_DIV = 50000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] hexs,
    input  logic [3:0]  points,
    input  logic [3:0]  LES,
    output logic [3:0]  AN,
    output logic [7:0]  SEG,
    output logic        frame_tick
);

    localparam int unsigned     PW         = $clog2(REFRESH_DIV);
    localparam logic [PW-1:0]   PRESC_LAST = PW'(REFRESH_DIV - 1);

    if (REFRESH_DIV < 2) begin : g_param_check
        $error("REFRESH_DIV must be at least 2");
    end

    logic [PW-1:0] r_presc;
    digit_idx_t    r_idx;
    logic [15:0]   r_hexs;
    logic [3:0]    r_points;
    logic [3:0]    r_les;
    logic [3:0]    r_an;
    logic [7:0]    r_seg;

    logic          w_presc_last;
    logic          w_tick;
    logic [3:0]    w_nibble;
    logic [6:0]    w_seg7;
    logic          w_blank;

    assign w_presc_last = (r_presc == PRESC_LAST);
    assign w_tick       = w_presc_last && (r_idx == 2'd3);
    assign frame_tick   = w_tick && !rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_presc <= '0;
            r_idx   <= '0;
        end else if (w_presc_last) begin
            r_presc <= '0;
            r_idx   <= r_idx + 2'd1;
        end else begin
            r_presc <= r_presc + PW'(1);
        end
    end

    // Snapshot tracks inputs during reset so the first post-reset frame is current.
    always_ff @(posedge clk) begin
        if (rst || w_tick) begin
            r_hexs   <= hexs;
            r_points <= points;
            r_les    <= LES;
        end
    end

    assign w_nibble = r_hexs[{r_idx, 2'b00} +: 4];

    hex7seg u_hex7seg (
        .i_hex (w_nibble),
        .o_seg (w_seg7)
    );

`ifdef SEG_LEADING_ZERO_BLANK_EN
    logic w_zero3;
    logic w_zero2;
    logic w_zero1;
    logic [3:0] w_lz_blank;

    assign w_zero3    = (r_hexs[15:12] == 4'h0);
    assign w_zero2    = w_zero3 && (r_hexs[11:8] == 4'h0);
    assign w_zero1    = w_zero2 && (r_hexs[7:4] == 4'h0);
    assign w_lz_blank = {w_zero3, w_zero2, w_zero1, 1'b0};
    assign w_blank    = r_les[r_idx] || w_lz_blank[r_idx];
`else
    assign w_blank    = r_les[r_idx];
`endif

    always_ff @(posedge clk) begin
        if (rst || w_blank) begin
            r_an  <= AN_OFF;
            r_seg <= SEG_BLANK;
        end else begin
            r_an  <= an_select(r_idx);
            r_seg <= {~r_points[r_idx], w_seg7};
        end
    end

    assign AN  = r_an;
    assign SEG = r_seg;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Directed self-checking bench for seg_scan_driver with REFRESH_DIV = 4.
module tb_seg_scan_driver;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] hexs;
    logic [3:0]  points;
    logic [3:0]  LES;
    logic [3:0]  AN;
    logic [7:0]  SEG;
    logic        frame_tick;

    int n_checks = 0;
    int n_fail   = 0;
    int k        = 0;

    logic [3:0] cur_an  [4];
    logic [7:0] cur_seg [4];
    logic [3:0] nxt_an  [4];
    logic [7:0] nxt_seg [4];

    seg_scan_driver #(.REFRESH_DIV(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .hexs       (hexs),
        .points     (points),
        .LES        (LES),
        .AN         (AN),
        .SEG        (SEG),
        .frame_tick (frame_tick)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s (k=%0d): got %0h expected %0h", tag, k, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // k counts cycles since reset release; each digit holds 4 cycles, frame is 16.
    task automatic run(input int n);
        int d;
        for (int j = 0; j < n; j++) begin
            step();
            if (k % 16 == 0) begin
                cur_an  = nxt_an;
                cur_seg = nxt_seg;
            end
            d = (k / 4) % 4;
            check("AN", {28'd0, AN}, {28'd0, cur_an[d]});
            check("SEG", {24'd0, SEG}, {24'd0, cur_seg[d]});
            check("frame_tick", {31'd0, frame_tick}, (k % 16 == 14) ? 32'd1 : 32'd0);
            k++;
        end
    endtask

    initial begin
        rst    = 1'b1;
        hexs   = 16'h1234;
        points = 4'b0000;
        LES    = 4'b0000;
        repeat (3) step();
        check("rst_AN", {28'd0, AN}, 32'hF);
        check("rst_SEG", {24'd0, SEG}, 32'hFF);
        check("rst_tick", {31'd0, frame_tick}, 32'd0);

        // Free run on 1234: digit0=4, digit1=3, digit2=2, digit3=1.
        rst = 1'b0;
        k   = 0;
        cur_an  = '{4'hE, 4'hD, 4'hB, 4'h7};
        cur_seg = '{8'h99, 8'hB0, 8'hA4, 8'hF9};
        nxt_an  = cur_an;
        nxt_seg = cur_seg;
        run(38);

        // Mid-frame change while digit 1 is shown; takes effect at k=48.
        hexs    = 16'hABCD;
        nxt_seg = '{8'hA1, 8'hC6, 8'h83, 8'h88};
        run(13);

        // dp on digit 1, blank digit 2, visible from k=64.
        points  = 4'b0010;
        LES     = 4'b0100;
        nxt_an  = '{4'hE, 4'hD, 4'hF, 4'h7};
        nxt_seg = '{8'hA1, 8'h46, 8'hFF, 8'h88};
        run(39);

        // k=89 was in the digit-2 slot; reset mid-frame.
        rst = 1'b1;
        step();
        check("midrst_AN", {28'd0, AN}, 32'hF);
        check("midrst_SEG", {24'd0, SEG}, 32'hFF);
        check("midrst_tick", {31'd0, frame_tick}, 32'd0);
        hexs   = 16'h0050;
        points = 4'b0000;
        LES    = 4'b0000;
        step();
        check("midrst2_AN", {28'd0, AN}, 32'hF);
        check("midrst2_SEG", {24'd0, SEG}, 32'hFF);

        rst = 1'b0;
        k   = 0;
`ifdef SEG_LEADING_ZERO_BLANK_EN
        cur_an  = '{4'hE, 4'hD, 4'hF, 4'hF};
        cur_seg = '{8'hC0, 8'h92, 8'hFF, 8'hFF};
`else
        cur_an  = '{4'hE, 4'hD, 4'hB, 4'h7};
        cur_seg = '{8'hC0, 8'h92, 8'hC0, 8'hC0};
`endif
        nxt_an  = cur_an;
        nxt_seg = cur_seg;
        run(32);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
